// File: rtl/lagarto0_iqueue.sv
// Fetch-to-decode instruction queue: compacts valid fetch slots into a circular buffer, issues one
// instruction per cycle. Define LAGARTO0_IQUEUE_BYPASS_EN for same-cycle issue into an empty queue.
module lagarto0_iqueue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISA_SIZE    = 32,
  parameter int unsigned ADDR_SIZE   = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            fetch_valid_i,
  output logic                            fetch_ready_o,
  input  logic [FETCH_WIDTH*ISA_SIZE-1:0] fetch_line_i,
  input  logic [ADDR_SIZE-1:0]            fetch_pc_i,
  input  logic [FETCH_WIDTH-1:0]          fetch_mask_i,
  output logic                            dec_valid_o,
  input  logic                            dec_ready_i,
  output logic [ISA_SIZE-1:0]             dec_instr_o,
  output logic [ADDR_SIZE-1:0]            dec_pc_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ISA_SIZE-1:0]  mem_instr [DEPTH];
  logic [ADDR_SIZE-1:0] mem_pc    [DEPTH];
  logic [PtrW-1:0]      rd_ptr, wr_ptr;
  logic [CntW-1:0]      count;

  logic                 push, buf_valid, pop;
  logic [ISA_SIZE-1:0]  slot_instr [FETCH_WIDTH];
  logic [ADDR_SIZE-1:0] slot_pc    [FETCH_WIDTH];
  logic                 wr_en      [FETCH_WIDTH];
  logic [PtrW-1:0]      wr_idx     [FETCH_WIDTH];
  logic                 byp_sel    [FETCH_WIDTH];
  logic [CntW-1:0]      n_wr;
  logic                 byp_valid, byp_take;
  logic [ISA_SIZE-1:0]  byp_instr;
  logic [ADDR_SIZE-1:0] byp_pc;

  assign fetch_ready_o = !rst_i && (count <= CntW'(DEPTH - FETCH_WIDTH));
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign buf_valid     = !rst_i && !flush_i && (count != '0);
  assign pop           = buf_valid && dec_ready_i;

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slot_instr[k] = fetch_line_i[k*ISA_SIZE +: ISA_SIZE];
      // Slot PCs are offsets from the line-aligned fetch address.
      slot_pc[k]    = (fetch_pc_i & ~ADDR_SIZE'(7)) + ADDR_SIZE'(4 * k);
    end
  end

  // Bypass selects the first valid slot when the buffer is empty.
  always_comb begin
    byp_valid = 1'b0;
    byp_instr = '0;
    byp_pc    = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) byp_sel[k] = 1'b0;
`ifdef LAGARTO0_IQUEUE_BYPASS_EN
    if (push && count == '0) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (fetch_mask_i[k] && !byp_valid) begin
          byp_valid  = 1'b1;
          byp_sel[k] = 1'b1;
          byp_instr  = slot_instr[k];
          byp_pc     = slot_pc[k];
        end
      end
    end
`endif
    byp_take = byp_valid && dec_ready_i;
  end

  // Compact surviving slots onto consecutive entries starting at wr_ptr.
  always_comb begin
    n_wr = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_en[k]  = 1'b0;
      wr_idx[k] = wr_ptr + n_wr[PtrW-1:0];
      if (push && fetch_mask_i[k] && !(byp_take && byp_sel[k])) begin
        wr_en[k] = 1'b1;
        n_wr     = n_wr + CntW'(1);
      end
    end
  end

  assign dec_valid_o = buf_valid || byp_valid;
  assign dec_instr_o = byp_valid ? byp_instr : mem_instr[rd_ptr];
  assign dec_pc_o    = byp_valid ? byp_pc : mem_pc[rd_ptr];
  assign count_o     = count;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (wr_en[k]) begin
        mem_instr[wr_idx[k]] <= slot_instr[k];
        mem_pc[wr_idx[k]]    <= slot_pc[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_wr[PtrW-1:0];
      rd_ptr <= rd_ptr + PtrW'(pop);
      count  <= count + n_wr - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_lagarto0_iqueue.sv
// Directed self-checking bench for lagarto0_iqueue (default build; bypass case under its macro).
module tb_lagarto0_iqueue;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_ready, dec_valid, dec_ready;
  logic [63:0] fetch_line, fetch_pc, dec_pc;
  logic [1:0]  fetch_mask;
  logic [31:0] dec_instr;
  logic [2:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] q_instr [$];
  logic [63:0] q_pc    [$];
  int unsigned seq;
  logic        exp_ready;

  always #5 clk = ~clk;

  lagarto0_iqueue dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .fetch_valid_i(fetch_valid),
    .fetch_ready_o(fetch_ready),
    .fetch_line_i (fetch_line),
    .fetch_pc_i   (fetch_pc),
    .fetch_mask_i (fetch_mask),
    .dec_valid_o  (dec_valid),
    .dec_ready_i  (dec_ready),
    .dec_instr_o  (dec_instr),
    .dec_pc_o     (dec_pc),
    .count_o      (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] line, input logic [63:0] pc,
                       input logic [1:0] mask, input logic rdy);
    fetch_valid = v;
    fetch_line  = line;
    fetch_pc    = pc;
    fetch_mask  = mask;
    dec_ready   = rdy;
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr, input logic [63:0] pc);
    check_eq({tag, ".valid"}, 64'(dec_valid), 64'd1);
    check_eq({tag, ".instr"}, 64'(dec_instr), 64'(instr));
    check_eq({tag, ".pc"}, dec_pc, pc);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, '0, '0, 2'b00, 1'b0);
    tick(); tick();
    check_eq("rst.fetch_ready", 64'(fetch_ready), 64'd0);
    check_eq("rst.dec_valid", 64'(dec_valid), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst.fetch_ready", 64'(fetch_ready), 64'd1);
    check_eq("post_rst.dec_valid", 64'(dec_valid), 64'd0);
    check_eq("post_rst.count", 64'(count), 64'd0);

    // Full packet issues slot0 then slot1.
    drive(1'b1, 64'hBBBB_BBBB_AAAA_AAAA, 64'h1000, 2'b11, 1'b0);
    tick();
    drive(1'b0, '0, '0, 2'b00, 1'b1);
    check_eq("t1.count2", 64'(count), 64'd2);
    check_head("t1.h0", 32'hAAAA_AAAA, 64'h1000);
    tick();
    check_eq("t1.count1", 64'(count), 64'd1);
    check_head("t1.h1", 32'hBBBB_BBBB, 64'h1004);
    tick();
    check_eq("t1.count0", 64'(count), 64'd0);
    check_eq("t1.empty", 64'(dec_valid), 64'd0);

    // Only slot1 valid.
    drive(1'b1, 64'h2222_2222_1111_1111, 64'h2008, 2'b10, 1'b0);
    tick();
    drive(1'b0, '0, '0, 2'b00, 1'b1);
    check_eq("t2.count", 64'(count), 64'd1);
    check_head("t2.h", 32'h2222_2222, 64'h200C);
    tick();
    check_eq("t2.count0", 64'(count), 64'd0);

    // Fill to DEPTH with decode stalled.
    drive(1'b1, 64'h31_0000_0030, 64'h3000, 2'b11, 1'b0);
    tick();
    check_eq("t3.count2", 64'(count), 64'd2);
    check_eq("t3.ready2", 64'(fetch_ready), 64'd1);
    drive(1'b1, 64'h33_0000_0032, 64'h3008, 2'b11, 1'b0);
    tick();
    check_eq("t3.count4", 64'(count), 64'd4);
    check_eq("t3.ready4", 64'(fetch_ready), 64'd0);
    drive(1'b1, 64'h99_0000_0099, 64'h9000, 2'b11, 1'b0);
    tick();
    check_eq("t3.count_hold", 64'(count), 64'd4);
    check_head("t3.h0", 32'h30, 64'h3000);
    drive(1'b0, '0, '0, 2'b00, 1'b1);
    tick();
    check_eq("t3.count3", 64'(count), 64'd3);
    check_eq("t3.ready3", 64'(fetch_ready), 64'd0);
    check_head("t3.h1", 32'h31, 64'h3004);
    tick();
    check_eq("t3.count2b", 64'(count), 64'd2);
    check_eq("t3.ready2b", 64'(fetch_ready), 64'd1);
    check_head("t3.h2", 32'h32, 64'h3008);
    tick();
    check_head("t3.h3", 32'h33, 64'h300C);
    tick();
    check_eq("t3.count0", 64'(count), 64'd0);

    // Sustained 2-in/1-out with wrap; model tracks order and backpressure.
    seq = 0;
    for (int i = 0; i < 20; i++) begin
      exp_ready = (q_instr.size() <= 2);
      drive(1'b1, {32'hC000_0000 + seq + 1, 32'hC000_0000 + seq}, 64'h4000 + 64'(4 * seq),
            2'b11, i != 0);
      check_eq("t4.ready", 64'(fetch_ready), 64'(exp_ready));
      check_eq("t4.count", 64'(count), 64'(q_instr.size()));
      if (q_instr.size() != 0) begin
        check_head("t4.h", q_instr[0], q_pc[0]);
        if (dec_ready) begin
          void'(q_instr.pop_front());
          void'(q_pc.pop_front());
        end
      end
      if (exp_ready) begin
        q_instr.push_back(32'hC000_0000 + seq);
        q_pc.push_back(64'h4000 + 64'(4 * seq));
        q_instr.push_back(32'hC000_0000 + seq + 1);
        q_pc.push_back(64'h4000 + 64'(4 * (seq + 1)));
        seq += 2;
      end
      tick();
    end
    drive(1'b0, '0, '0, 2'b00, 1'b1);
    for (int i = 0; i < 8 && q_instr.size() != 0; i++) begin
      check_head("t4.drain", q_instr[0], q_pc[0]);
      void'(q_instr.pop_front());
      void'(q_pc.pop_front());
      tick();
    end
    check_eq("t4.count0", 64'(count), 64'd0);

    // Flush with concurrent push and pop.
    drive(1'b1, 64'h51_0000_0050, 64'h5000, 2'b11, 1'b0);
    tick();
    drive(1'b1, 64'h53_0000_0052, 64'h5008, 2'b01, 1'b0);
    tick();
    check_eq("t5.count3", 64'(count), 64'd3);
    flush = 1'b1;
    drive(1'b1, 64'h5F_0000_005E, 64'h5010, 2'b11, 1'b1);
    check_eq("t5.flush_valid", 64'(dec_valid), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 2'b00, 1'b1);
    check_eq("t5.count0", 64'(count), 64'd0);
    check_eq("t5.valid_n1", 64'(dec_valid), 64'd0);
    check_eq("t5.ready_n1", 64'(fetch_ready), 64'd1);
    tick();
    check_eq("t5.still_empty", 64'(dec_valid), 64'd0);
    drive(1'b1, 64'h61_0000_0060, 64'h6000, 2'b01, 1'b0);
    tick();
    drive(1'b0, '0, '0, 2'b00, 1'b1);
    check_eq("t5.count1", 64'(count), 64'd1);
    check_head("t5.h", 32'h60, 64'h6000);
    tick();
    check_eq("t5.drained", 64'(count), 64'd0);

`ifdef LAGARTO0_IQUEUE_BYPASS_EN
    drive(1'b1, 64'h71_0000_0070, 64'h7000, 2'b11, 1'b1);
    check_head("t6.byp", 32'h70, 64'h7000);
    tick();
    drive(1'b0, '0, '0, 2'b00, 1'b1);
    check_eq("t6.count1", 64'(count), 64'd1);
    check_head("t6.h", 32'h71, 64'h7004);
    tick();
    check_eq("t6.count0", 64'(count), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
